// File: rtl/bus_arb_pkg.sv
// Shared constants, state encoding and the round-robin pick helper for bus_arbiter4.
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan r starting at ptr and wrapping mod NUM_REQ; the first set bit wins.
  function automatic pick_t rr_pick(logic [NUM_REQ-1:0] r, logic [SEL_W-1:0] ptr);
    pick_t            p;
    logic [SEL_W-1:0] j;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ptr + SEL_W'(k);
      if (r[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_arbiter4_if.sv
// Request/data/grant bundle between the four requesters and the arbiter.
interface bus_arbiter4_if
  import bus_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) ();

  logic [NUM_REQ-1:0] req;
  logic [WIDTH-1:0]   din0;
  logic [WIDTH-1:0]   din1;
  logic [WIDTH-1:0]   din2;
  logic [WIDTH-1:0]   din3;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   bus;
  logic               bus_valid;

  modport master (
    output req, din0, din1, din2, din3,
    input  grant, sel, bus, bus_valid
  );

  modport slave (
    input  req, din0, din1, din2, din3,
    output grant, sel, bus, bus_valid
  );

endinterface

// File: rtl/mux4_bus.sv
// Plain WIDTH-bit 4:1 multiplexer driven by a binary select.
module mux4_bus #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] m
);

  always_comb begin
    m = u;
    unique case (s)
      2'd0: m = u;
      2'd1: m = v;
      2'd2: m = w;
      2'd3: m = x;
    endcase
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter with bounded hold time that owns the select of a shared 4:1 bus mux.
module bus_arbiter4
  import bus_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4
) (
  input logic           Clock,
  input logic           Reset,
  bus_arbiter4_if.slave bif
);

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         hcnt_q, hcnt_d;

  logic [NUM_REQ-1:0] others;
  pick_t              pick_all;
  pick_t              pick_oth;
  logic               take_new;
  logic [SEL_W-1:0]   new_idx;
  logic [WIDTH-1:0]   mux_out;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    take_new = 1'b0;
    new_idx  = sel_q;

    // Requests from everyone except the current owner; in IDLE grant_q is zero.
    others   = bif.req & ~grant_q;
    pick_all = rr_pick(bif.req, ptr_q);
    pick_oth = rr_pick(others, ptr_q);

    unique case (state_q)
      IDLE: begin
        if (pick_all.found) begin
          take_new = 1'b1;
          new_idx  = pick_all.idx;
        end
      end
      GRANT: begin
        if (!bif.req[sel_q]) begin
          if (pick_oth.found) begin
            take_new = 1'b1;
            new_idx  = pick_oth.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end else if (hcnt_q == HoldLast && pick_oth.found) begin
          take_new = 1'b1;
          new_idx  = pick_oth.idx;
        end else if (hcnt_q < HoldLast) begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
    endcase

    if (take_new) begin
      state_d          = GRANT;
      grant_d          = '0;
      grant_d[new_idx] = 1'b1;
      sel_d            = new_idx;
      valid_d          = 1'b1;
      ptr_d            = new_idx + SEL_W'(1);
      hcnt_d           = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
    end
  end

  mux4_bus #(
    .WIDTH(WIDTH)
  ) u_mux (
    .s(sel_q),
    .u(bif.din0),
    .v(bif.din1),
    .w(bif.din2),
    .x(bif.din3),
    .m(mux_out)
  );

  assign bif.bus       = valid_q ? mux_out : '0;
  assign bif.grant     = grant_q;
  assign bif.sel       = sel_q;
  assign bif.bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: a behavioural model queues expected outputs per edge.
module tb_bus_arbiter4;

  localparam int unsigned W    = 16;
  localparam int          MAXH = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  always #5 Clock = ~Clock;

  bus_arbiter4_if #(.WIDTH(W)) bif ();

  bus_arbiter4 #(
    .WIDTH(W),
    .MAX_HOLD(MAXH)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bif(bif)
  );

  typedef struct {
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] bus;
  } exp_t;

  exp_t         sb[$];
  exp_t         last;
  int           n_checks = 0;
  int           n_err    = 0;
  logic [W-1:0] din[4];
  bit           rand_din = 1'b0;

  // Reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rs);
    logic [3:0] oth;
    int         nw;
    nw  = -1;
    oth = r;
    if (rs) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
      m_sel  = 0;
    end else if (!m_busy) begin
      nw = pick(r, m_ptr);
    end else begin
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        nw = pick(oth, m_ptr);
        if (nw < 0) m_busy = 1'b0;
      end else if (m_cnt == MAXH - 1) begin
        nw = pick(oth, m_ptr);
      end else begin
        m_cnt++;
      end
    end
    if (nw >= 0) begin
      m_busy  = 1'b1;
      m_owner = nw;
      m_sel   = nw;
      m_ptr   = (nw + 1) % 4;
      m_cnt   = 0;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.valid = m_busy;
    e.grant = m_busy ? (4'(1) << m_owner) : 4'h0;
    e.sel   = 2'(m_sel);
    e.bus   = m_busy ? din[m_sel] : '0;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] r, input logic rs, input bit glitch);
    exp_t e;
    @(negedge Clock);
    if (rand_din) begin
      for (int i = 0; i < 4; i++) din[i] = W'($urandom);
    end
    bif.din0 = din[0];
    bif.din1 = din[1];
    bif.din2 = din[2];
    bif.din3 = din[3];
    if (glitch) begin
      bif.req = ~r;
      #1;
      check_eq("stable_grant", bif.grant, last.grant);
      #1;
    end
    Reset   = rs;
    bif.req = r;
    model_edge(r, rs);
    push_exp();
    @(posedge Clock);
    #1;
    check_eq("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("grant", bif.grant, e.grant);
      check_eq("sel", bif.sel, e.sel);
      check_eq("bus_valid", bif.bus_valid, e.valid);
      check_eq("bus", bif.bus, e.bus);
      check_eq("onehot", 32'($onehot0(bif.grant)), 1);
      last = e;
    end
  endtask

  initial begin
    last    = '{grant: 4'h0, sel: 2'd0, valid: 1'b0, bus: '0};
    din[0]  = 16'hA000;
    din[1]  = 16'hB001;
    din[2]  = 16'hC002;
    din[3]  = 16'hD003;
    bif.req = 4'h0;

    // Reset with all requests pending, then release
    step(4'hF, 1'b1, 1'b0);
    step(4'hF, 1'b1, 1'b0);
    check_eq("rst_grant", bif.grant, 4'h0);
    step(4'hF, 1'b0, 1'b0);
    check_eq("first_grant", bif.grant, 4'b0001);
    check_eq("first_bus", bif.bus, 16'hA000);

    // Sole requester keeps the bus indefinitely
    step(4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      check_eq("sole_grant", bif.grant, 4'b0100);
      check_eq("sole_bus", bif.bus, 16'hC002);
    end

    // Everyone requesting: MAX_HOLD cycles each, rotating and wrapping
    step(4'h0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(4'hF, 1'b0, 1'b0);
      check_eq("rr_seq", bif.grant, 4'(1) << ((k / MAXH) % 4));
    end

    // Owner 1 releases while 0 and 3 wait: hand over to 3 with no bubble
    step(4'h0, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b1001, 1'b0, 1'b0);
    check_eq("release_next", bif.grant, 4'b1000);
    step(4'h0, 1'b0, 1'b0);
    check_eq("idle_valid", bif.bus_valid, 1'b0);
    check_eq("idle_bus", bif.bus, 16'h0000);

    // Reset mid-grant clears grant and pointer
    step(4'h0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    check_eq("midrst_grant", bif.grant, 4'h0);
    step(4'b0110, 1'b0, 1'b0);
    check_eq("midrst_ptr", bif.grant, 4'b0010);

    // Requests wiggled between edges, random data
    rand_din = 1'b1;
    for (int k = 0; k < 30; k++) step(4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Random traffic with occasional reset
    for (int k = 0; k < 200; k++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 19) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
